// File: rtl/aging_sensor_scheduler.sv
// aging_sensor_scheduler: sequences the aging-sensor bank (clear, measure, settle, evaluate each sensor in turn)
// Ports:
//   clk_i / reset_i      reference clock, synchronous active-high reset
//   start_i              level, begins a sweep when idle
//   continuous_i         auto-restart sweeps after the idle gap (sampled at sweep end)
//   aged_clear_i         clears all sticky aged flags
//   sensor_count_i       flattened sensor counts, sensor i at [i*CW +: CW]
//   sensor_enable_o      one-hot oscillator enable (or zero)
//   sensor_clear_o       1-cycle counter clear for the selected sensor
//   busy_o               high outside IDLE
//   result_valid_o       1-cycle pulse per evaluated sensor
//   result_index_o/count_o  index and sampled count of the latest result
//   sweep_done_o         1-cycle pulse after the last sensor's result
//   aged_o               sticky per-sensor aged flags
module aging_sensor_scheduler #(
  parameter int SENSOR_COUNT    = 2,
  parameter int COUNTER_WIDTH   = 32,
  parameter int MEAS_DURATION   = 1000000,
  parameter int IDLE_DURATION   = 16,
  parameter int AGING_THRESHOLD = 6,
  localparam int IDX_W = SENSOR_COUNT > 1 ? $clog2(SENSOR_COUNT) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  start_i,
  input  logic                                  continuous_i,
  input  logic                                  aged_clear_i,
  input  logic [SENSOR_COUNT*COUNTER_WIDTH-1:0] sensor_count_i,
  output logic [SENSOR_COUNT-1:0]               sensor_enable_o,
  output logic                                  sensor_clear_o,
  output logic                                  busy_o,
  output logic                                  result_valid_o,
  output logic [IDX_W-1:0]                      result_index_o,
  output logic [COUNTER_WIDTH-1:0]              result_count_o,
  output logic                                  sweep_done_o,
  output logic [SENSOR_COUNT-1:0]               aged_o
);
  localparam int TMAX = MEAS_DURATION > IDLE_DURATION ? (MEAS_DURATION > 2 ? MEAS_DURATION : 2)
                                                      : (IDLE_DURATION > 2 ? IDLE_DURATION : 2);
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, MEASURE, SETTLE, EVAL, DONE, GAP} state_t;
  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [SENSOR_COUNT-1:0]    aged_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q - TW'(1);
    case (state_q)
      IDLE: begin
        state_d = start_i ? CLEAR : IDLE;
        idx_d   = '0;
      end
      CLEAR: begin
        state_d = MEASURE;
        timer_d = TW'(MEAS_DURATION - 1);
      end
      MEASURE: if (timer_q == '0) begin
        state_d = SETTLE;
        timer_d = TW'(1);
      end
      SETTLE: state_d = timer_q == '0 ? EVAL : SETTLE;
      EVAL: begin
        state_d = idx_q == IDX_W'(SENSOR_COUNT - 1) ? DONE : (IDLE_DURATION == 0 ? CLEAR : GAP);
        idx_d   = idx_q == IDX_W'(SENSOR_COUNT - 1) ? idx_q : idx_q + IDX_W'(1);
        timer_d = TW'(IDLE_DURATION - 1);
      end
      DONE: begin
        state_d = !continuous_i ? IDLE : (IDLE_DURATION == 0 ? CLEAR : GAP);
        idx_d   = '0;
        timer_d = TW'(IDLE_DURATION - 1);
      end
      GAP: state_d = timer_q == '0 ? CLEAR : GAP;
      default: state_d = IDLE;
    endcase
  end
  // A flag set during EVAL survives a simultaneous aged_clear; the rest clear.
  always_comb begin
    aged_d = aged_clear_i ? '0 : aged_o;
    if (state_q == EVAL && result_count_o < COUNTER_WIDTH'(AGING_THRESHOLD)) aged_d[result_index_o] = 1'b1;
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      timer_q         <= '0;
      sensor_enable_o <= '0;
      sensor_clear_o  <= 1'b0;
      busy_o          <= 1'b0;
      result_valid_o  <= 1'b0;
      result_index_o  <= '0;
      result_count_o  <= '0;
      sweep_done_o    <= 1'b0;
      aged_o          <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      timer_q         <= timer_d;
      sensor_enable_o <= state_d == MEASURE ? SENSOR_COUNT'(1) << idx_d : '0;
      sensor_clear_o  <= state_d == CLEAR;
      busy_o          <= state_d != IDLE;
      result_valid_o  <= state_d == EVAL;
      sweep_done_o    <= state_d == DONE;
      aged_o          <= aged_d;
      if (state_d == EVAL) begin
        result_index_o <= idx_q;
        result_count_o <= sensor_count_i[int'(idx_q)*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_aging_sensor_scheduler.sv
// tb_aging_sensor_scheduler: vectors, hand sequences and random stimulus against a timeline model
module tb_aging_sensor_scheduler;
  localparam int SC = 2, CW = 32, MD = 8, ID = 3, TH = 6, IW = 1;
  localparam int P = 4 + MD + ID;
  localparam int L = SC * (4 + MD) + (SC - 1) * ID + 1;
  logic clk = 1'b0, reset, start, continuous, aged_clear;
  logic [SC*CW-1:0] cnt;
  logic [SC-1:0] sensor_enable, aged;
  logic sensor_clear, busy, result_valid, sweep_done;
  logic [IW-1:0] result_index;
  logic [CW-1:0] result_count;
  int checks = 0, errors = 0;
  bit mon = 0;
  always #5 clk = ~clk;
  aging_sensor_scheduler #(.SENSOR_COUNT(SC), .COUNTER_WIDTH(CW), .MEAS_DURATION(MD),
    .IDLE_DURATION(ID), .AGING_THRESHOLD(TH)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .continuous_i(continuous),
    .aged_clear_i(aged_clear), .sensor_count_i(cnt), .sensor_enable_o(sensor_enable),
    .sensor_clear_o(sensor_clear), .busy_o(busy), .result_valid_o(result_valid),
    .result_index_o(result_index), .result_count_o(result_count),
    .sweep_done_o(sweep_done), .aged_o(aged));
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  // Model: mode 0 idle, 1 in sweep at cycle t from the first CLEAR, 2 in the post-sweep gap.
  int mode = 0, t = 0, g = 0;
  logic [IW-1:0] m_idx = '0;
  logic [CW-1:0] m_cnt = '0;
  logic [SC-1:0] m_aged = '0;
  always @(posedge clk) begin : model
    int k, off;
    logic [SC-1:0] na;
    k = t / P;
    off = t % P;
    if (reset) begin
      mode = 0; t = 0; g = 0; m_idx = '0; m_cnt = '0; m_aged = '0;
    end else begin
      na = aged_clear ? '0 : m_aged;
      if (mode == 1 && k < SC && off == MD + 3 && m_cnt < TH) na[k] = 1'b1;
      m_aged = na;
      if (mode == 1 && k < SC && off == MD + 2) begin
        m_idx = IW'(k);
        m_cnt = cnt[k*CW +: CW];
      end
      case (mode)
        0: if (start) begin mode = 1; t = 0; end
        1: if (t == L - 1) begin
             if (!continuous) mode = 0;
             else if (ID == 0) t = 0;
             else begin mode = 2; g = 0; end
           end else t++;
        default: if (g == ID - 1) begin mode = 1; t = 0; end else g++;
      endcase
    end
  end
  always @(negedge clk) if (mon) begin : monitor
    int k, off;
    logic sw;
    logic [SC-1:0] een;
    k = t / P;
    off = t % P;
    sw = mode == 1 && k < SC;
    een = (sw && off >= 1 && off <= MD) ? SC'(1) << k : '0;
    chk("enable", sensor_enable, een);
    chk("onehot", $onehot0(sensor_enable), 1);
    chk("clear", sensor_clear, sw && off == 0);
    chk("busy", busy, mode != 0);
    chk("valid", result_valid, sw && off == MD + 3);
    chk("done", sweep_done, mode == 1 && t == L - 1);
    chk("index", result_index, m_idx);
    chk("count", result_count, m_cnt);
    chk("aged", aged, m_aged);
  end
  task automatic tick; @(negedge clk); endtask
  function automatic logic sig(input int w);
    case (w)
      0: sig = sweep_done;
      1: sig = sensor_clear;
      2: sig = |sensor_enable;
      3: sig = result_valid;
      default: sig = !busy;
    endcase
  endfunction
  task automatic wait_sig(input int w, input string nm);
    int n;
    n = 0;
    while (!sig(w) && n < 200) begin tick; n++; end
    if (n >= 200) chk({"timeout_", nm}, 0, 1);
  endtask
  task automatic pulse_start; start = 1; tick; start = 0; endtask
  typedef struct { logic [CW-1:0] s0, s1; bit clr; logic [SC-1:0] aged; } vec_t;
  vec_t tbl[6];
  initial begin
    int n;
    tbl[0] = '{32'd50, 32'd100, 1'b1, 2'b00};
    tbl[1] = '{32'd5, 32'd6, 1'b1, 2'b01};
    tbl[2] = '{32'd100, 32'd100, 1'b0, 2'b01};
    tbl[3] = '{32'd0, 32'd2, 1'b1, 2'b11};
    tbl[4] = '{32'd6, 32'd5, 1'b1, 2'b10};
    tbl[5] = '{32'hFFFF_FFFF, 32'd6, 1'b1, 2'b00};
    reset = 1; start = 0; continuous = 0; aged_clear = 0; cnt = '0;
    tick;
    chk("rst_enable", sensor_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clear", sensor_clear, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_aged", aged, 0);
    chk("rst_count", result_count, 0);
    reset = 0; mon = 1;
    tick;
    cnt = {32'd100, 32'd50};
    pulse_start;
    chk("s1_clear", sensor_clear, 1);
    for (int i = 0; i < MD; i++) begin tick; chk("s1_enable_on", sensor_enable, 2'b01); end
    tick; chk("s1_enable_off", sensor_enable, 0);
    tick; tick;
    chk("s1_valid0", result_valid, 1);
    chk("s1_count0", result_count, 50);
    for (int i = 0; i < ID + 1; i++) tick;
    chk("s1_clear1", sensor_clear, 1);
    wait_sig(3, "s1_v1");
    chk("s1_count1", result_count, 100);
    chk("s1_index1", result_index, 1);
    tick; chk("s1_done", sweep_done, 1);
    tick; chk("s1_idle", busy, 0);
    for (int i = 0; i < 6; i++) begin
      cnt = {tbl[i].s1, tbl[i].s0};
      if (tbl[i].clr) begin aged_clear = 1; tick; aged_clear = 0; end
      pulse_start;
      wait_sig(3, "tbl_v0");
      chk("tbl_idx0", result_index, 0);
      chk("tbl_cnt0", result_count, tbl[i].s0);
      tick;
      wait_sig(3, "tbl_v1");
      chk("tbl_idx1", result_index, 1);
      chk("tbl_cnt1", result_count, tbl[i].s1);
      wait_sig(0, "tbl_done");
      tick;
      chk("tbl_aged", aged, tbl[i].aged);
      chk("tbl_busy", busy, 0);
    end
    continuous = 1;
    cnt = {32'd100, 32'd50};
    pulse_start;
    wait_sig(0, "c_done");
    n = 0;
    do begin tick; n++; end while (!sensor_clear && n < 50);
    chk("c_gap", n - 1, ID);
    chk("c_index_restart", sensor_enable === 2'b00 && busy, 1);
    continuous = 0;
    wait_sig(0, "c_done2");
    tick; chk("c_stop", busy, 0);
    cnt = {32'd2, 32'd100};
    aged_clear = 1; tick; aged_clear = 0;
    pulse_start;
    wait_sig(0, "col_pre"); tick;
    chk("col_pre_aged", aged, 2'b10);
    cnt = {32'd100, 32'd2};
    pulse_start;
    wait_sig(3, "col_v0");
    aged_clear = 1; tick; aged_clear = 0;
    wait_sig(0, "col_done"); tick;
    chk("col_aged", aged, 2'b01);
    pulse_start;
    wait_sig(2, "r_en");
    tick; tick; tick;
    chk("r_4th", sensor_enable, 2'b01);
    reset = 1; tick; reset = 0;
    chk("r_enable", sensor_enable, 0);
    chk("r_busy", busy, 0);
    chk("r_aged", aged, 0);
    pulse_start;
    wait_sig(2, "r_en2");
    n = 0;
    while (sensor_enable == 2'b01 && n < 50) begin tick; n++; end
    chk("r_window", n, MD);
    wait_sig(0, "r_done"); tick;
    start = 1;
    tick; tick;
    chk("h_busy", busy, 1);
    wait_sig(0, "h_done");
    tick; chk("h_idle", busy, 0);
    tick; chk("h_restart", sensor_clear, 1);
    start = 0;
    wait_sig(0, "h_done2"); tick;
    for (int i = 0; i < 4000; i++) begin
      start = $urandom_range(7) == 0;
      if ($urandom_range(49) == 0) continuous = ~continuous;
      aged_clear = $urandom_range(39) == 0;
      reset = $urandom_range(599) == 0;
      cnt = {CW'($urandom_range(11)), CW'($urandom_range(11))};
      tick;
    end
    start = 0; continuous = 0; aged_clear = 0; reset = 0;
    wait_sig(4, "final_idle");
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
